// File: rtl/avalon_mm_cmd_master.sv
// Avalon-MM master that turns a valid/ready command stream into single read/write transfers.
// It keeps one transfer in flight, aborts on a waitrequest timeout, and returns one response per command.
module avalon_mm_cmd_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_be_i,
  output logic [ADDR_W-1:0]   address_o,
  output logic                chipselect_o,
  output logic                read_n_o,
  output logic                write_n_o,
  output logic [DATA_W-1:0]   writedata_o,
  output logic [DATA_W/8-1:0] byteenable_o,
  input  logic                waitrequest_i,
  input  logic [DATA_W-1:0]   readdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o
);

  // state | meaning
  // IDLE  | ready for a command; strobes released
  // XFER  | strobes driven, waiting for waitrequest low or timeout
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RESP} state_t;

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_W-1:0]     address_q;
  logic                  chipselect_q;
  logic                  read_n_q;
  logic                  write_n_q;
  logic [DATA_W-1:0]     writedata_q;
  logic [DATA_W/8-1:0]   byteenable_q;
  logic                  rsp_valid_q;
  logic [DATA_W-1:0]     rsp_rdata_q;
  logic                  rsp_err_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      address_q    <= '0;
      chipselect_q <= 1'b0;
      read_n_q     <= 1'b1;
      write_n_q    <= 1'b1;
      writedata_q  <= '0;
      byteenable_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            address_q    <= cmd_addr_i;
            writedata_q  <= cmd_wdata_i;
            byteenable_q <= cmd_be_i;
            chipselect_q <= 1'b1;
            read_n_q     <= cmd_write_i;
            write_n_q    <= !cmd_write_i;
            cnt_q        <= '0;
            state_q      <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!waitrequest_i) begin
            chipselect_q <= 1'b0;
            read_n_q     <= 1'b1;
            write_n_q    <= 1'b1;
            rsp_rdata_q  <= read_n_q ? '0 : readdata_i;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= ST_RESP;
          end else if (TIMEOUT != 0) begin
            // Saturating count; reaching TIMEOUT on this edge aborts the transfer.
            if (cnt_q < CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_MAX - CNT_W'(1)) begin
              chipselect_q <= 1'b0;
              read_n_q     <= 1'b1;
              write_n_q    <= 1'b1;
              rsp_rdata_q  <= '0;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = (state_q == ST_IDLE) && !reset_i;
  assign address_o    = address_q;
  assign chipselect_o = chipselect_q;
  assign read_n_o     = read_n_q;
  assign write_n_o    = write_n_q;
  assign writedata_o  = writedata_q;
  assign byteenable_o = byteenable_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_avalon_mm_cmd_master.sv
// Bench for avalon_mm_cmd_master: a table of commands with expected Avalon and response results,
// scoreboarded on both sides, plus sequences for backpressure, reset mid-transfer and back-to-back.
module tb_avalon_mm_cmd_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic [3:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  avalon_mm_cmd_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_be_i(cmd_be),
    .address_o(address), .chipselect_o(chipselect), .read_n_o(read_n), .write_n_o(write_n),
    .writedata_o(writedata), .byteenable_o(byteenable),
    .waitrequest_i(waitrequest), .readdata_i(readdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          nwait;
    logic [31:0] rdata;
    int          cycles;
    logic        err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cycles;
  } av_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  av_t  av_q[$];
  rsp_t rsp_q[$];

  int n_err = 0;
  int n_chk = 0;
  int cycle = 0;
  int wait_cnt = 0;
  logic [31:0] slave_rdata = 32'h0;
  int cs_cycles = 0;
  logic prev_cs = 1'b0;
  int n_xfer = 0;
  int n_rsp = 0;
  int last_hs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cycle++;

  // Slave model and Avalon-side monitor, both evaluated away from the active edge.
  always @(negedge clk) begin
    if (chipselect && !reset) begin
      if (wait_cnt > 0) begin
        waitrequest = 1'b1;
        wait_cnt--;
      end else begin
        waitrequest = 1'b0;
      end
    end else begin
      waitrequest = 1'b0;
    end
    readdata = waitrequest ? 32'hBAD0BAD0 : slave_rdata;

    if (reset) begin
      cs_cycles = 0;
      prev_cs = 1'b0;
    end else begin
      if (chipselect) begin
        cs_cycles++;
        if (av_q.size() == 0) begin
          chk("av_unexpected_strobe", 1'b1, 1'b0);
        end else begin
          chk("av_address", address, av_q[0].addr);
          chk("av_byteenable", byteenable, av_q[0].be);
          chk("av_write_n", write_n, !av_q[0].wr);
          chk("av_read_n", read_n, av_q[0].wr);
          if (av_q[0].wr) chk("av_writedata", writedata, av_q[0].wdata);
        end
      end else if (prev_cs) begin
        if (av_q.size() == 0) begin
          chk("av_unexpected_end", 1'b1, 1'b0);
        end else begin
          chk("av_strobe_cycles", cs_cycles, av_q[0].cycles);
          void'(av_q.pop_front());
          n_xfer++;
        end
        cs_cycles = 0;
      end
      prev_cs = chipselect;
    end
  end

  // Response-side monitor.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      chk("cmd_ready_in_resp", cmd_ready, 1'b0);
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        chk("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
        chk("rsp_err", rsp_err, rsp_q[0].err);
        if (rsp_ready) begin
          void'(rsp_q.pop_front());
          n_rsp++;
          last_hs = cycle + 1;
        end
      end
    end
  end

  // Presents a command and returns just after the accepting edge; cmd_valid is left high.
  task automatic send(input vec_t v, output int acc);
    int budget;
    av_t  a;
    rsp_t r;
    bit   ok;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_be    = v.be;
    budget = 0;
    ok = 1'b0;
    acc = -1;
    while (!ok && budget < 300) begin
      @(negedge clk);
      if (cmd_ready && !reset) ok = 1'b1;
      budget++;
    end
    if (!ok) begin
      chk("cmd_accept_timeout", 1'b0, 1'b1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cycle;
      wait_cnt = v.nwait;
      slave_rdata = v.rdata;
      a.wr = v.wr; a.addr = v.addr; a.wdata = v.wdata; a.be = v.be; a.cycles = v.cycles;
      av_q.push_back(a);
      r.rdata = v.exp_rdata; r.err = v.err;
      rsp_q.push_back(r);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || av_q.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_complete", (rsp_q.size() == 0 && av_q.size() == 0), 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t v;
    int acc;
    int acc_b2b[4];
    int t;
    int x0, r0;

    //          wr    addr   wdata          be     nwait rdata         cyc err   exp_rdata
    vecs[0] = '{1'b1, 4'd0,  32'h0000BEEF, 4'hF, 0,   32'h0,        1,  1'b0, 32'h0};
    vecs[1] = '{1'b0, 4'd2,  32'h0,        4'hF, 3,   32'h00001234, 4,  1'b0, 32'h00001234};
    vecs[2] = '{1'b1, 4'd5,  32'hA5A5A5A5, 4'h3, 2,   32'h0,        3,  1'b0, 32'h0};
    vecs[3] = '{1'b0, 4'd15, 32'h0,        4'hF, 0,   32'hDEADBEEF, 1,  1'b0, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 4'd7,  32'h0,        4'hC, 7,   32'h000055AA, 8,  1'b0, 32'h000055AA};
    vecs[5] = '{1'b0, 4'd3,  32'h0,        4'hF, 100, 32'h0000FFFF, 8,  1'b1, 32'h0};
    vecs[6] = '{1'b1, 4'd1,  32'h12345678, 4'h8, 0,   32'h0,        1,  1'b0, 32'h0};
    vecs[7] = '{1'b1, 4'd9,  32'h0F0F0F0F, 4'hF, 20,  32'h0,        8,  1'b1, 32'h0};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    rsp_ready = 1'b1;
    waitrequest = 1'b0;
    readdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_address", address, 4'h0);
    chk("rst_chipselect", chipselect, 1'b0);
    chk("rst_read_n", read_n, 1'b1);
    chk("rst_write_n", write_n, 1'b1);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_byteenable", byteenable, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      send(v, acc);
      cmd_valid = 1'b0;
      if (v.nwait == 0) begin
        chk("lat_strobe_cs", chipselect, 1'b1);
        chk("lat_strobe_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_rsp_valid", rsp_valid, 1'b1);
        chk("lat_cs_released", chipselect, 1'b0);
      end
      drain();
    end

    // Response backpressure with a new command waiting.
    rsp_ready = 1'b0;
    v = '{1'b0, 4'd9, 32'h0, 4'hF, 1, 32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D};
    send(v, acc);
    cmd_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("bp_rsp_seen", rsp_valid, 1'b1);
    v = '{1'b1, 4'd4, 32'h0BADCAFE, 4'hF, 0, 32'h0, 1, 1'b0, 32'h0};
    fork
      send(v, acc);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_cmd_ready_low", cmd_ready, 1'b0);
          chk("bp_rsp_valid_held", rsp_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    cmd_valid = 1'b0;
    chk("bp_accept_after_hs", acc, last_hs + 1);
    drain();

    // Reset while a read is stalled.
    v = '{1'b0, 4'd10, 32'h0, 4'hF, 1000, 32'h11111111, 0, 1'b0, 32'h0};
    send(v, acc);
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("mid_read_n_low", read_n, 1'b0);
    chk("mid_cs_high", chipselect, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_cs_released", chipselect, 1'b0);
    chk("async_read_n_released", read_n, 1'b1);
    chk("async_rsp_valid", rsp_valid, 1'b0);
    chk("async_cmd_ready", cmd_ready, 1'b0);
    av_q.delete();
    rsp_q.delete();
    wait_cnt = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk("post_rst_rsp_valid", rsp_valid, 1'b0);
    v = '{1'b0, 4'd6, 32'h0, 4'hF, 2, 32'h600D600D, 3, 1'b0, 32'h600D600D};
    send(v, acc);
    cmd_valid = 1'b0;
    drain();

    // Back-to-back writes with cmd_valid held.
    x0 = n_xfer;
    r0 = n_rsp;
    for (int k = 0; k < 4; k++) begin
      v = '{1'b1, 4'(k), 32'h10000000 + 32'(k), 4'hF, 0, 32'h0, 1, 1'b0, 32'h0};
      send(v, acc_b2b[k]);
      if (k > 0) chk("b2b_accept_gap", acc_b2b[k] - acc_b2b[k-1], 3);
    end
    cmd_valid = 1'b0;
    drain();
    chk("b2b_transfers", n_xfer - x0, 4);
    chk("b2b_responses", n_rsp - r0, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
